uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (16x baud tick).
//
// Receives 1 start bit, DBIT data bits (LSB first), an optional even-parity
// bit and 1 stop bit. Each bit is sampled in its middle by counting s_tick
// strobes: 8 ticks into the start bit, then every 16 ticks.
//
// Optional feature (compile-time macro):
//   UART_RX_PARITY_EN  adds a PARITY state after the data bits and the
//                      parity_err output. When undefined the frame is
//                      start + DBIT data + stop and parity_err does not exist.
//
// Parameters:
//   DBIT     data bits per frame
//   SB_TICK  s_tick periods spent in the stop bit
//
// Ports:
//   clk           single clock, all state changes on its rising edge
//   reset         asynchronous, active-high reset
//   rx            asynchronous serial line, idles high
//   s_tick        one-clk strobe at 16x baud
//   rx_dout       last received data word
//   rx_done_tick  one-clk pulse when a frame completes
//   frame_err     1 if the stop bit of the last completed frame was low
//   parity_err    (UART_RX_PARITY_EN only) 1 on even-parity mismatch
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            frame_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] NLast  = NW'(DBIT - 1);
  localparam logic [3:0]    SbLast = 4'(SB_TICK - 1);
  localparam logic [3:0]    SMid   = 4'd7;
  localparam logic [3:0]    SEnd   = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // Synchronizer
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  // FSM and datapath
  state_e          r_state;
  state_e          w_state_next;
  logic [3:0]      r_s;
  logic [3:0]      w_s_next;
  logic [NW-1:0]   r_n;
  logic [NW-1:0]   w_n_next;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] w_b_next;
  logic [DBIT:0]   w_shift;
  logic            r_armed;
  logic            w_armed_next;

  // Registered outputs
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            w_frame_end;

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic w_par_next;
  logic r_perr;
  logic w_perr_calc;
`endif

  assign w_rx_s = r_sync2;

  // Line synchronizer; resets to the idle (high) level so a reset never
  // looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next-state and datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_shift      = {w_rx_s, r_b};
`ifdef UART_RX_PARITY_EN
    w_par_next   = r_par;
`endif

    unique case (r_state)
      StIdle: begin
        // Start detection does not wait for a tick.
        if (!w_rx_s && r_armed) begin
          w_state_next = StStart;
          w_s_next     = '0;
        end
      end

      StStart: begin
        if (s_tick) begin
          if (r_s == SMid) begin
            if (!w_rx_s) begin
              w_state_next = StData;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              // Glitch or noise: back to idle without a pulse.
              w_state_next = StIdle;
              w_s_next     = '0;
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end

      StData: begin
        if (s_tick) begin
          if (r_s == SEnd) begin
            w_s_next = '0;
            w_b_next = w_shift[DBIT:1];
            if (r_n == NLast) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = StParity;
`else
              w_state_next = StStop;
`endif
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (r_s == SEnd) begin
            w_s_next     = '0;
            w_par_next   = w_rx_s;
            w_state_next = StStop;
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end
`endif

      StStop: begin
        if (s_tick) begin
          if (r_s == SbLast) begin
            w_s_next     = '0;
            w_state_next = StIdle;
          end else begin
            w_s_next = r_s + 4'd1;
          end
        end
      end

      default: begin
        w_state_next = StIdle;
        w_s_next     = '0;
      end
    endcase

    // armed only accumulates a high line level while idle; it is cleared
    // on leaving idle and stays clear until the frame is over. A frame that
    // ends in a break therefore re-enters idle unarmed and cannot re-trigger
    // until the line has been seen high again.
    if (r_state == StIdle && w_state_next == StIdle) begin
      w_armed_next = r_armed | w_rx_s;
    end else begin
      w_armed_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 3: output decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_frame_end = (r_state == StStop) && s_tick && (r_s == SbLast);
`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data and parity bit must be zero.
    w_perr_calc = (^r_b) ^ r_par;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_armed <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_armed <= w_armed_next;
      r_done  <= w_frame_end;
      if (w_frame_end) begin
        r_dout <= r_b;
        r_ferr <= ~w_rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_par <= w_par_next;
      if (w_frame_end) begin
        r_perr <= w_perr_calc;
      end
    end
  end

  assign parity_err = r_perr;
`endif

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (DBIT=8, SB_TICK=16).
// Line frames are built from data words; a scoreboard of expected
// {word, frame_err, parity_err} is popped on every rx_done_tick.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned DBIT    = 8;
  localparam int unsigned SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  // With s_tick constantly high: 2 sync flops + 1 idle->start clk, 8 ticks to
  // mid start bit, 16 per data/parity bit, SB_TICK for the stop bit, then the
  // pulse one clk after the final stop tick.
  localparam int LAT = 3 + 8 + 16 * (DBIT + PBITS) + SB_TICK;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`else
  logic       parity_err;
  assign parity_err = 1'b0;
`endif

  uart_rx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         div;
    int         gap;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  int         wide = 0;
  logic       prev_done = 1'b0;
  int         cyc = 0;
  int         t_start = 0;
  int         t_done = 0;
  logic       mark = 1'b0;
  int         div = 1;
  int         phase = 0;
  logic [7:0] last_dout = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    sb.push_back(e);
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic sample();
    exp_t e;
    if (rx_done_tick) begin
      pulses++;
      t_done = cyc;
      if (prev_done) wide++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected pulse: got rx_dout %0h expected no pulse", rx_dout);
      end else begin
        e = sb.pop_front();
        check("rx_dout", 32'(rx_dout), 32'(e.d));
        check("frame_err", 32'(frame_err), 32'(e.fe));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(e.pe));
`endif
        last_dout = e.d;
      end
    end
    prev_done = rx_done_tick;
  endtask

  task automatic clk_step(input logic v);
    @(negedge clk);
    cyc++;
    sample();
    rx     = v;
    s_tick = (phase == div - 1);
    phase  = (phase + 1) % div;
    if (mark) begin
      t_start = cyc;
      mark    = 1'b0;
    end
  endtask

  task automatic set_div(input int d);
    div   = d;
    phase = 0;
  endtask

  task automatic drive_tick(input logic v);
    do begin
      clk_step(v);
    end while (s_tick == 1'b0);
  endtask

  task automatic send_bit(input logic v);
    repeat (16) drive_tick(v);
  endtask

  task automatic idle(input int n);
    repeat (n) clk_step(1'b1);
  endtask

  // pflip inverts the even-parity bit (ignored without the parity option).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    mark = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`else
    if (pflip) $display("note: parity flip ignored");
`endif
    send_bit(stop);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   p0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, div: 1, gap: 20, exp_d: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, div: 2, gap: 7,  exp_d: 8'h3C, exp_fe: 1'b0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, div: 3, gap: 13, exp_d: 8'h00, exp_fe: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, div: 1, gap: 0,  exp_d: 8'hFF, exp_fe: 1'b0};
    vecs[4] = '{data: 8'h81, stop: 1'b1, div: 4, gap: 5,  exp_d: 8'h81, exp_fe: 1'b0};
    vecs[5] = '{data: 8'h5A, stop: 1'b1, div: 2, gap: 30, exp_d: 8'h5A, exp_fe: 1'b0};

    // Reset state
    set_div(1);
    reset = 1'b1;
    idle(3);
    check("reset rx_dout", 32'(rx_dout), 32'h0);
    check("reset rx_done_tick", 32'(rx_done_tick), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    reset = 1'b0;
    idle(10);

    // Latency with s_tick held high, frame 0xA5
    p0 = pulses;
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(10);
    check("A5 pulse count", 32'(pulses - p0), 32'd1);
    check("A5 latency", 32'(t_done - t_start), 32'(LAT));

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      set_div(vecs[i].div);
      idle(vecs[i].gap);
      p0 = pulses;
      push_exp(vecs[i].exp_d, vecs[i].exp_fe, 1'b0);
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      idle(4);
      check("table pulse count", 32'(pulses - p0), 32'd1);
    end

    // False start: 4 ticks low then high
    set_div(2);
    idle(10);
    p0 = pulses;
    repeat (4) drive_tick(1'b0);
    repeat (40) drive_tick(1'b1);
    check("false start pulse count", 32'(pulses - p0), 32'd0);
    check("false start rx_dout held", 32'(rx_dout), 32'(last_dout));

    // Framing error then break held low for 40 ticks
    set_div(1);
    idle(10);
    p0 = pulses;
    push_exp(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("break first pulse count", 32'(pulses - p0), 32'd1);
    repeat (40) drive_tick(1'b0);
    check("break no extra pulse", 32'(pulses - p0), 32'd1);
    repeat (40) drive_tick(1'b1);
    check("break released no pulse", 32'(pulses - p0), 32'd1);
    check("break rx_dout held", 32'(rx_dout), 32'h3C);
    check("break frame_err held", 32'(frame_err), 32'h1);

    // Back-to-back frames, no idle gap
    p0 = pulses;
    push_exp(8'h00, 1'b0, 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(5);
    check("back-to-back pulse count", 32'(pulses - p0), 32'd2);

    // Reset in the middle of data bit 3 of 0x5A, then frame 0x81
    idle(10);
    p0 = pulses;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'((8'h5A >> i) & 8'h01));
    repeat (8) drive_tick(1'b1);
    reset = 1'b1;
    idle(3);
    check("mid-frame reset rx_dout", 32'(rx_dout), 32'h0);
    check("mid-frame reset frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    idle(20);
    push_exp(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(5);
    check("reset recovery pulse count", 32'(pulses - p0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 1 (good), then parity bit 0 (bad)
    idle(10);
    p0 = pulses;
    push_exp(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    push_exp(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(5);
    check("parity pulse count", 32'(pulses - p0), 32'd2);
`endif

    // Random frames: data, tick divider, idle gap (0 = back-to-back), parity
    for (int k = 0; k < 30; k++) begin
      logic [7:0] d;
      logic       pf;
      d  = 8'($urandom);
      pf = 1'($urandom_range(0, 1));
`ifndef UART_RX_PARITY_EN
      pf = 1'b0;
`endif
      set_div(int'($urandom_range(1, 4)));
      idle(int'($urandom_range(0, 30)));
      push_exp(d, 1'b0, pf);
      send_frame(d, 1'b1, pf);
    end
    idle(20);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    check("pulse width one clk", 32'(wide), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
